dual_fetch_ctrl: RTL and testbench

- Sequences the dual-instruction fetch buffer in two phases.
- LOAD phase: accepts a program stream from the loader through a valid/ready handshake and generates buffer write enables and addresses.
- RUN phase: drives the pair read address `pc`. The buffer returns words at `pc` and `pc+1`.
- Issues pairs to the dual-issue decode stage under a valid/ready handshake, handles branch redirects, and flags end of program.

---
 rtl/dual_fetch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dual_fetch_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_fetch_ctrl.sv
// dual_fetch_ctrl: load/run sequencer for the dual-issue fetch buffer.
// Optional perf counters (stall_cnt, pair_cnt) under FETCH_PERF_CNT_EN.
module dual_fetch_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              issue_valid,
  output logic              issue_second_valid,
  input  logic              issue_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              busy,
  output logic              done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       pair_cnt
`endif
);

  localparam int LW = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LW-1:0]     len_q, len_d;
  logic              iv_q, iv_d;
  logic              sv_q, sv_d;

  logic          accept;
  logic          last_acc;
  logic          hs;
  logic [LW-1:0] pc_ext;
  logic [LW-1:0] pc_p1;
  logic [LW-1:0] pc_p2;
  logic [LW-1:0] pc_p3;
  logic [LW-1:0] tgt;

  assign load_ready  = (state_q == S_LOAD);
  assign accept      = load_valid & load_ready;
  assign buf_wr_en   = accept;
  assign buf_wr_addr = wr_q;
  assign last_acc    = accept &
                       (load_last | (wr_q == ADDR_W'(DEPTH - 1)));
  assign hs          = (state_q == S_RUN) & iv_q &
                       issue_ready & ~branch_valid;

  assign pc_ext = {1'b0, pc_q};
  assign pc_p1  = pc_ext + LW'(1);
  assign pc_p2  = pc_ext + LW'(2);
  assign pc_p3  = pc_ext + LW'(3);
  assign tgt    = {1'b0, branch_target & ~ADDR_W'(1)};

  assign pc                 = pc_q;
  assign issue_valid        = iv_q;
  assign issue_second_valid = sv_q;
  assign busy               = (state_q == S_LOAD) | (state_q == S_RUN);
  assign done               = (state_q == S_DONE);

  // Register the sequencer state and its datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      iv_q    <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      iv_q    <= iv_d;
      sv_q    <= sv_d;
    end
  end

  // Next state: load counting, pair stepping, branch bubble.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    pc_d    = pc_q;
    len_d   = len_q;
    iv_d    = iv_q;
    sv_d    = sv_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          wr_d    = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_d = wr_q + ADDR_W'(1);
        end
        if (last_acc) begin
          len_d   = {1'b0, wr_q} + LW'(1);
          pc_d    = '0;
          state_d = S_RUN;
          iv_d    = 1'b1;
          sv_d    = (wr_q != '0);
        end
      end
      S_RUN: begin
        if (branch_valid) begin
          pc_d = tgt[ADDR_W-1:0];
          iv_d = 1'b0;
          sv_d = 1'b0;
          if (tgt >= len_q) begin
            state_d = S_DONE;
          end
        end else if (hs) begin
          if (pc_p2 >= len_q) begin
            state_d = S_DONE;
            iv_d    = 1'b0;
            sv_d    = 1'b0;
          end else begin
            pc_d = pc_p2[ADDR_W-1:0];
            iv_d = 1'b1;
            sv_d = (pc_p3 < len_q);
          end
        end else if (!iv_q) begin
          iv_d = 1'b1;
          sv_d = (pc_p1 < len_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic go;
  logic stall_ev;

  assign go       = start &
                    ((state_q == S_IDLE) | (state_q == S_DONE));
  assign stall_ev = (state_q == S_RUN) & iv_q & ~issue_ready;

  // Saturating stall and issued-pair counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      pair_cnt  <= '0;
    end else if (go) begin
      stall_cnt <= '0;
      pair_cnt  <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (hs && pair_cnt != '1) begin
        pair_cnt <= pair_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dual_fetch_ctrl.sv
// tb_dual_fetch_ctrl: randomized and directed checks of dual_fetch_ctrl
// against a cycle-level behavioural model of the load/run sequence.
module tb_dual_fetch_ctrl;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [ADDR_W-1:0] pc;
  logic              issue_valid;
  logic              issue_second_valid;
  logic              issue_ready;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              busy;
  logic              done;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       pair_cnt;
`endif

  dual_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .load_valid(load_valid),
    .load_last(load_last),
    .load_ready(load_ready),
    .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .pc(pc),
    .issue_valid(issue_valid),
    .issue_second_valid(issue_second_valid),
    .issue_ready(issue_ready),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .busy(busy),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt(stall_cnt),
    .pair_cnt(pair_cnt),
`endif
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // model: phase 0 idle, 1 load, 2 run, 3 done
  int m_state;
  int m_pc;
  int m_len;
  int m_wr;
  bit m_bub;
  int m_stall;
  int m_pair;
  int issued[$];

  logic [25:0] o;
  logic [25:0] e;

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_len   = 0;
    m_wr    = 0;
    m_bub   = 0;
    m_stall = 0;
    m_pair  = 0;
  endtask

  task automatic step(input bit st, input bit lv, input bit ll,
                      input bit ir, input bit bv, input int bt,
                      output logic [25:0] ov, output logic [25:0] ev);
    bit ive;
    start         = st;
    load_valid    = lv;
    load_last     = ll;
    issue_ready   = ir;
    branch_valid  = bv;
    branch_target = bt[ADDR_W-1:0];
    @(negedge clk);
    ive = (m_state == 2) && !m_bub;
    ev = {m_state == 1, lv && (m_state == 1),
          10'(m_wr % DEPTH), 10'(m_pc),
          ive, ive && (m_pc + 1 < m_len),
          (m_state == 1) || (m_state == 2), m_state == 3};
    ov = {load_ready, buf_wr_en, buf_wr_addr, pc,
          issue_valid, issue_second_valid, busy, done};
    if (issue_valid && ir && !bv) issued.push_back(int'(pc));
    case (m_state)
      0, 3: if (st) begin
        m_state = 1;
        m_wr    = 0;
        m_stall = 0;
        m_pair  = 0;
      end
      1: if (lv) begin
        if (ll || m_wr == DEPTH - 1) begin
          m_len   = m_wr + 1;
          m_pc    = 0;
          m_state = 2;
          m_bub   = 0;
        end
        m_wr = (m_wr + 1) % DEPTH;
      end
      2: begin
        if (!m_bub && !ir) m_stall++;
        if (bv) begin
          m_pc  = bt & (DEPTH - 2);
          m_bub = 1;
          if (m_pc >= m_len) m_state = 3;
        end else begin
          if (!m_bub && ir) begin
            m_pair++;
            if (m_pc + 2 >= m_len) m_state = 3;
            else m_pc = m_pc + 2;
          end
          m_bub = 0;
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    o = {load_ready, buf_wr_en, buf_wr_addr, pc,
         issue_valid, issue_second_valid, busy, done};
    tests++;
    if (o !== 26'b0) begin
      fails++;
      $display("FAIL reset outs got %h want 0", o);
    end
`ifdef FETCH_PERF_CNT_EN
    tests++;
    if (stall_cnt !== 0 || pair_cnt !== 0) begin
      fails++;
      $display("FAIL reset cnt got %0d/%0d want 0/0",
               stall_cnt, pair_cnt);
    end
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load6();
    issued.delete();
    step(1, 0, 0, 1, 0, 0, o, e);
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL load6 start got %h want %h", o, e);
    end
    for (int i = 0; i < 11; i++) begin
      step(0, i < 6, i == 5, 1, 0, 0, o, e);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL load6 cyc%0d got %h want %h", i, o, e);
      end
    end
    tests++;
    if (issued.size() != 3 || issued[0] != 0 ||
        issued[1] != 2 || issued[2] != 4 || done !== 1'b1) begin
      fails++;
      $display("FAIL load6 pairs got n=%0d done=%b want 0,2,4 done=1",
               issued.size(), done);
    end
  endtask

  task automatic test_load5();
    issued.delete();
    step(1, 0, 0, 1, 0, 0, o, e);
    for (int i = 0; i < 10; i++) begin
      step(0, i < 5, i == 4, 1, 0, 0, o, e);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL load5 cyc%0d got %h want %h", i, o, e);
      end
    end
    tests++;
    if (issued.size() != 3 || issued[2] != 4 || done !== 1'b1) begin
      fails++;
      $display("FAIL load5 pairs got n=%0d done=%b want 3 done=1",
               issued.size(), done);
    end
  endtask

  task automatic test_full_depth();
    int bad;
    bad = 0;
    issued.delete();
    step(1, 0, 0, 1, 0, 0, o, e);
    for (int c = 0; c < 3000 && m_state == 1; c++) begin
      step(0, $urandom_range(0, 3) != 0, 0, 1, 0, 0, o, e);
      if (o !== e) bad++;
    end
    for (int c = 0; c < 520; c++) begin
      step(0, 1, 0, 1, 0, 0, o, e);
      if (o !== e) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL full cycles got %0d bad cycles want 0", bad);
    end
    tests++;
    if (issued.size() != 512 || issued[511] != 1022 || done !== 1'b1)
    begin
      fails++;
      $display("FAIL full pairs got n=%0d done=%b want 512 done=1",
               issued.size(), done);
    end
  endtask

  task automatic test_branch();
    bit fired;
    bit bv;
    fired = 0;
    issued.delete();
    step(1, 0, 0, 1, 0, 0, o, e);
    for (int i = 0; i < 8; i++) step(0, 1, i == 7, 1, 0, 0, o, e);
    for (int c = 0; c < 8; c++) begin
      bv = !fired && m_state == 2 && !m_bub && m_pc == 2;
      step(0, 0, 0, 1, bv, 7, o, e);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL branch cyc%0d got %h want %h", c, o, e);
      end
      if (bv) begin
        fired = 1;
        tests++;
        if (pc !== 10'd6 || issue_valid !== 1'b0) begin
          fails++;
          $display("FAIL branch bubble got pc=%0d iv=%b want 6/0",
                   pc, issue_valid);
        end
      end
    end
    tests++;
    if (issued.size() != 2 || issued[0] != 0 || issued[1] != 6) begin
      fails++;
      $display("FAIL branch pairs got n=%0d want 0,6", issued.size());
    end
`ifdef FETCH_PERF_CNT_EN
    tests++;
    if (pair_cnt !== 32'd2) begin
      fails++;
      $display("FAIL branch pair_cnt got %0d want 2", pair_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    step(1, 0, 0, 1, 0, 0, o, e);
    for (int i = 0; i < 8; i++) step(0, 1, i == 7, 0, 0, 0, o, e);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0, 0, o, e);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL stall cyc%0d got %h want %h", c, o, e);
      end
    end
    tests++;
    if (pc !== 10'd0 || issue_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall hold got pc=%0d iv=%b want 0/1",
               pc, issue_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    tests++;
    if (stall_cnt !== 32'd3) begin
      fails++;
      $display("FAIL stall_cnt got %0d want 3", stall_cnt);
    end
`endif
    step(0, 0, 0, 1, 1, 20, o, e);
    tests++;
    if (done !== 1'b1 || pc !== 10'd20 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall far-branch got done=%b pc=%0d want 1/20",
               done, pc);
    end
  endtask

  task automatic test_mid_reset();
    step(1, 0, 0, 1, 0, 0, o, e);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, o, e);
    load_valid = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    o = {load_ready, buf_wr_en, buf_wr_addr, pc,
         issue_valid, issue_second_valid, busy, done};
    tests++;
    if (o !== 26'b0) begin
      fails++;
      $display("FAIL midrst outs got %h want 0", o);
    end
    model_reset();
    load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    issued.delete();
    step(1, 0, 0, 1, 0, 0, o, e);
    for (int i = 0; i < 8; i++) begin
      step(0, i < 4, i == 3, 1, 0, 0, o, e);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL midrst reload cyc%0d got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_random();
    int len;
    int bad;
    bit lv;
    bit bv;
    for (int it = 0; it < 30; it++) begin
      bad = 0;
      len = $urandom_range(1, 40);
      step(1, 0, 0, 1, 0, 0, o, e);
      if (o !== e) bad++;
      for (int c = 0; c < 1500 && m_state != 3; c++) begin
        lv = $urandom_range(0, 3) != 0;
        bv = c < 100 && $urandom_range(0, 19) == 0;
        step($urandom_range(0, 19) == 0, lv, m_wr == len - 1,
             $urandom_range(0, 9) < 7, bv, $urandom_range(0, 63), o, e);
        if (o !== e) bad++;
      end
      step(0, 0, 0, 1, 0, 0, o, e);
      if (o !== e) bad++;
      tests++;
      if (bad != 0 || done !== 1'b1) begin
        fails++;
        $display("FAIL random it%0d len%0d got bad=%0d done=%b want 0/1",
                 it, len, bad, done);
      end
`ifdef FETCH_PERF_CNT_EN
      tests++;
      if (stall_cnt !== 32'(m_stall) || pair_cnt !== 32'(m_pair)) begin
        fails++;
        $display("FAIL random cnt it%0d got %0d/%0d want %0d/%0d",
                 it, stall_cnt, pair_cnt, m_stall, m_pair);
      end
`endif
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b0;
    start         = 1'b0;
    load_valid    = 1'b0;
    load_last     = 1'b0;
    issue_ready   = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    model_reset();
    test_reset();
    test_load6();
    test_load5();
    test_full_depth();
    test_branch();
    test_stall();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
